// File: rtl/frame_buff.sv
// Store-and-forward frame buffer: a frame is readable only once it is committed without error; reads have 1-cycle latency.
// No write backpressure (frames that do not fit are dropped); afull is the pause hint. Optional FRAME_BUFF_DROP_CNT_EN enables drop_cnt.
module frame_buff #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int FRM_W     = 4,
  parameter int AFULL_LVL = (1 << ADDR_W) - 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              frm_avail,
  output logic [ADDR_W:0]   frm_len,
  output logic              afull,
  output logic [15:0]       drop_cnt
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LQ_DEPTH = 1 << FRM_W;
  localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_TH = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [FRM_W:0]  LQ_FULL  = (FRM_W+1)'(LQ_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DISCARD} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   lq_mem [LQ_DEPTH];

  logic [ADDR_W:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0] commit_ptr, commit_ptr_nxt;
  logic [ADDR_W:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] occ, occ_nxt;
  logic [ADDR_W:0] commit_len;
  logic [FRM_W-1:0] lq_wp, lq_rp;
  logic [FRM_W:0]   lq_cnt;

  logic store_full, lq_full;
  logic mem_we, push, pop, rd_go, drop;

  assign occ        = wr_ptr - rd_ptr;
  assign store_full = (occ == FULL_OCC);
  assign lq_full    = (lq_cnt == LQ_FULL);
  assign frm_avail  = (lq_cnt != '0);
  assign frm_len    = frm_avail ? lq_mem[lq_rp] : '0;

  // The read side can never overtake commit_ptr: it only walks frames whose length is queued.
  assign rd_go      = rd_en && frm_avail;
  assign pop        = rd_go && ((rd_cnt + 1'b1) == frm_len);
  assign rd_ptr_nxt = rd_go ? rd_ptr + 1'b1 : rd_ptr;
  assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    mem_we         = 1'b0;
    push           = 1'b0;
    drop           = 1'b0;
    commit_len     = wr_ptr - commit_ptr + 1'b1;
    if (wr_valid) begin
      case (state)
        DISCARD: begin
          if (wr_last) state_nxt = IDLE;
        end
        IDLE, FILL: begin
          // Length-queue space is only checked at frame start; it can only grow afterwards.
          if ((state == IDLE && lq_full) || store_full) begin
            wr_ptr_nxt = commit_ptr;
            drop       = 1'b1;
            state_nxt  = wr_last ? IDLE : DISCARD;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (wr_last) begin
              state_nxt = IDLE;
              if (wr_err) begin
                wr_ptr_nxt = commit_ptr;
                drop       = 1'b1;
              end else begin
                push           = 1'b1;
                commit_ptr_nxt = wr_ptr + 1'b1;
              end
            end else begin
              state_nxt = FILL;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      lq_wp      <= '0;
      lq_rp      <= '0;
      lq_cnt     <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
      afull      <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      if (push) lq_wp <= lq_wp + 1'b1;
      if (pop)  lq_rp <= lq_rp + 1'b1;
      if (push && !pop)      lq_cnt <= lq_cnt + 1'b1;
      else if (pop && !push) lq_cnt <= lq_cnt - 1'b1;
      if (pop)        rd_cnt <= '0;
      else if (rd_go) rd_cnt <= rd_cnt + 1'b1;
      rd_valid <= rd_go;
      rd_last  <= pop;
      if (rd_go) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
      // Registered from next-state pointers so afull tracks the current occupancy.
      afull <= (occ_nxt >= AFULL_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    if (push)   lq_mem[lq_wp] <= commit_len;
  end

`ifdef FRAME_BUFF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 1'b1;
  end
`else
  logic drop_unused;
  assign drop_unused = drop;
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_frame_buff.sv
// Bench for frame_buff: two instances (default and ADDR_W=6/FRM_W=2) share one stimulus stream and are checked against a frame-level model.
module tb_frame_buff;

  localparam int CAP   [2] = '{2048, 64};
  localparam int LQCAP [2] = '{16, 4};
  localparam int LVL   [2] = '{1984, 48};
`ifdef FRAME_BUFF_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  logic       clk, rst_n;
  logic       wr_valid, wr_last, wr_err, rd_en;
  logic [7:0] wr_data;

  logic [7:0]  rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, rd_last0, rd_last1;
  logic        frm_avail0, frm_avail1, afull0, afull1;
  logic [11:0] frm_len0;
  logic [6:0]  frm_len1;
  logic [15:0] drop_cnt0, drop_cnt1;

  frame_buff dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_last(rd_last0),
    .frm_avail(frm_avail0), .frm_len(frm_len0), .afull(afull0), .drop_cnt(drop_cnt0)
  );

  frame_buff #(.ADDR_W(6), .FRM_W(2), .AFULL_LVL(48)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_last(rd_last1),
    .frm_avail(frm_avail1), .frm_len(frm_len1), .afull(afull1), .drop_cnt(drop_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: committed words in a circular array, frame lengths in a second one.
  logic [7:0] sd [2][4096];
  int  ln [2][64];
  int  st_head [2], st_cnt [2], cur_n [2], ln_head [2], ln_cnt [2], rd_cnt [2], drops [2];
  bit  open_f [2], disc [2];
  bit  e_rv [2], e_rl [2];
  logic [7:0] e_rd [2];
  bit  m_full, m_lqf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        st_head[k] = 0; st_cnt[k] = 0; cur_n[k] = 0; ln_head[k] = 0; ln_cnt[k] = 0;
        rd_cnt[k] = 0; drops[k] = 0; open_f[k] = 0; disc[k] = 0; e_rv[k] = 0; e_rl[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_full = (st_cnt[k] + cur_n[k]) == CAP[k];
        m_lqf  = ln_cnt[k] == LQCAP[k];
        e_rv[k] = 0;
        e_rl[k] = 0;
        if (rd_en && ln_cnt[k] > 0) begin
          e_rv[k] = 1;
          e_rd[k] = sd[k][st_head[k]];
          st_head[k] = (st_head[k] + 1) % 4096;
          st_cnt[k]--;
          rd_cnt[k]++;
          if (rd_cnt[k] == ln[k][ln_head[k]]) begin
            e_rl[k] = 1;
            ln_head[k] = (ln_head[k] + 1) % 64;
            ln_cnt[k]--;
            rd_cnt[k] = 0;
          end
        end
        if (wr_valid) begin
          if (disc[k]) begin
            if (wr_last) disc[k] = 0;
          end else if ((!open_f[k] && m_lqf) || m_full) begin
            drops[k]++;
            cur_n[k] = 0;
            open_f[k] = 0;
            disc[k] = !wr_last;
          end else begin
            sd[k][(st_head[k] + st_cnt[k] + cur_n[k]) % 4096] = wr_data;
            cur_n[k]++;
            open_f[k] = 1;
            if (wr_last) begin
              if (wr_err) drops[k]++;
              else begin
                ln[k][(ln_head[k] + ln_cnt[k]) % 64] = cur_n[k];
                ln_cnt[k]++;
                st_cnt[k] += cur_n[k];
              end
              cur_n[k] = 0;
              open_f[k] = 0;
            end
          end
        end
      end
    end
  end

  function automatic int exp_drop(input int k);
    if (DROP_ON == 0) return 0;
    return (drops[k] > 65535) ? 65535 : drops[k];
  endfunction

  task automatic cmp(input int k, input logic rv, input logic rl, input logic [7:0] rd,
                     input logic fa, input logic [11:0] fl, input logic af, input logic [15:0] dc);
    chk($sformatf("rd_valid%0d", k), rv, e_rv[k]);
    if (e_rv[k]) begin
      chk($sformatf("rd_data%0d", k), rd, e_rd[k]);
      chk($sformatf("rd_last%0d", k), rl, e_rl[k]);
    end
    chk($sformatf("frm_avail%0d", k), fa, ln_cnt[k] > 0);
    if (ln_cnt[k] > 0) chk($sformatf("frm_len%0d", k), fl, ln[k][ln_head[k]]);
    chk($sformatf("afull%0d", k), af, (st_cnt[k] + cur_n[k]) >= LVL[k]);
    chk($sformatf("drop_cnt%0d", k), dc, exp_drop(k));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, rd_valid0, rd_last0, rd_data0, frm_avail0, frm_len0, afull0, drop_cnt0);
      cmp(1, rd_valid1, rd_last1, rd_data1, frm_avail1, 12'(frm_len1), afull1, drop_cnt1);
    end
  end

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic wl, input logic we, input logic re);
    wr_valid = wv; wr_data = wd; wr_last = wl; wr_err = we; rd_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // rdp: percent chance of rd_en per cycle; rnd=0 writes data equal to the word index.
  task automatic send(input int len, input bit err, input int rdp, input bit rnd);
    for (int i = 0; i < len; i++)
      cyc(1'b1, rnd ? 8'($urandom) : 8'(i), i == len - 1, err && (i == len - 1),
          $urandom_range(99) < rdp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags0"}, {rd_valid0, rd_last0, frm_avail0, afull0}, 0);
    chk({tag, "_flags1"}, {rd_valid1, rd_last1, frm_avail1, afull1}, 0);
    chk({tag, "_rd_data0"}, rd_data0, 0);
    chk({tag, "_rd_data1"}, rd_data1, 0);
    chk({tag, "_frm_len0"}, frm_len0, 0);
    chk({tag, "_frm_len1"}, frm_len1, 0);
    chk({tag, "_drop_cnt0"}, drop_cnt0, 0);
    chk({tag, "_drop_cnt1"}, drop_cnt1, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_last = 1'b0; wr_err = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 6000 && (frm_avail0 || frm_avail1 || rd_valid0 || rd_valid1); c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (rd_valid0 && rd_last0) n0++;
      if (rd_valid1 && rd_last1) n1++;
    end
    rd_en = 1'b0;
    chk("drain_done", {frm_avail0, frm_avail1}, 0);
  endtask

  int n0, n1;

  initial begin
    wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0; wr_err = 1'b0; rd_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 64-word good frame, read back with rd_en held
    send(64, 1'b0, 0, 1'b0);
    idle();
    chk("len64_dut0", frm_len0, 64);
    chk("len64_dut1", frm_len1, 64);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rd64_valid", rd_valid0, 1);
      chk("rd64_data", rd_data0, i);
      chk("rd64_last", rd_last0, i == 63);
    end
    idle();
    chk("rd64_avail_fall", {frm_avail0, frm_avail1}, 0);

    // 100-word frame marked bad
    do_reset("rst_a");
    send(100, 1'b1, 0, 1'b1);
    idle();
    chk("err_avail", {frm_avail0, frm_avail1}, 0);
    chk("err_afull1", afull1, 0);
    chk("err_drop0", drop_cnt0, DROP_ON);
    chk("err_drop1", drop_cnt1, DROP_ON);

    // 70-word frame overflows the small store, 10-word follower survives
    do_reset("rst_b");
    send(70, 1'b0, 0, 1'b1);
    send(10, 1'b0, 0, 1'b1);
    idle();
    chk("ovf_len1", frm_len1, 10);
    chk("ovf_len0", frm_len0, 70);
    chk("ovf_drop1", drop_cnt1, DROP_ON);
    drain(n0, n1);
    chk("ovf_frames0", n0, 2);
    chk("ovf_frames1", n1, 1);

    // five 1-word frames against a 4-entry length queue
    do_reset("rst_c");
    for (int i = 0; i < 5; i++) send(1, 1'b0, 0, 1'b1);
    idle();
    chk("lq_len1", frm_len1, 1);
    chk("lq_drop1", drop_cnt1, DROP_ON);
    chk("lq_drop0", drop_cnt0, 0);
    drain(n0, n1);
    chk("lq_frames0", n0, 5);
    chk("lq_frames1", n1, 4);

    // commit of B on the same edge as the last read of A
    do_reset("rst_d");
    send(3, 1'b0, 0, 1'b1);
    idle();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), i == 3, 1'b0, i >= 1);
    rd_en = 1'b0;
    chk("same_last0", rd_last0, 1);
    chk("same_avail0", frm_avail0, 1);
    chk("same_len0", frm_len0, 4);
    chk("same_avail1", frm_avail1, 1);
    chk("same_len1", frm_len1, 4);
    drain(n0, n1);

    // reset mid-frame with three frames stored
    do_reset("rst_e");
    for (int i = 0; i < 3; i++) send(5, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    do_reset("rst_mid");
    send(6, 1'b0, 0, 1'b1);
    idle();
    chk("post_rst_len0", frm_len0, 6);
    drain(n0, n1);
    chk("post_rst_frames0", n0, 1);
    chk("post_rst_frames1", n1, 1);

    // randomized traffic with concurrent reads
    do_reset("rst_f");
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(3)) cyc(1'b0, 8'h00, 1'b0, 1'b0, $urandom_range(1));
      send($urandom_range(1, 90), $urandom_range(9) == 0, 50, 1'b1);
    end
    drain(n0, n1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buff.md
FRAME_BUFF -- requirements
Module: frame_buff

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the data path in bits.
REQ-002 SHALL have parameter ADDR_W, default 11: data store holds 2^ADDR_W words.
REQ-003 SHALL have parameter FRM_W, default 4: length queue holds 2^FRM_W frame lengths.
REQ-004 SHALL have parameter AFULL_LVL, default 2^ADDR_W-64: occupancy threshold for afull.
REQ-005 SHALL have these ports: clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have these ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have these ports: wr_valid  in  1  wr_data holds a word of the current frame.
REQ-008 SHALL have these ports: wr_data  in  DATA_W  write word.
REQ-009 SHALL have these ports: wr_last  in  1  qualified by wr_valid; final word of the frame.
REQ-010 SHALL have these ports: wr_err  in  1  qualified by wr_valid and wr_last; frame is bad.
REQ-011 SHALL have these ports: rd_en  in  1  pop one word of the head frame.
REQ-012 SHALL have these ports: rd_data  out  DATA_W  read word.
REQ-013 SHALL have these ports: rd_valid  out  1  rd_data is valid this cycle.
REQ-014 SHALL have these ports: rd_last  out  1  qualified by rd_valid; final word of the head frame.
REQ-015 SHALL have these ports: frm_avail  out  1  at least one committed frame is stored.
REQ-016 SHALL have these ports: frm_len  out  ADDR_W+1  word count of the head frame; valid while frm_avail.
REQ-017 SHALL have these ports: afull  out  1  occupancy >= AFULL_LVL (drives pause request).
REQ-018 SHALL have these ports: drop_cnt  out  16  frames discarded (see Configuration).

Function
REQ-019 SHALL store frames store-and-forward: a frame becomes readable only after its wr_last word is accepted with wr_err=0.
REQ-020 SHALL use ADDR_W+1-bit write, commit and read pointers; full = (wr_ptr-rd_ptr) == 2^ADDR_W; wrap is modulo 2^(ADDR_W+1).
REQ-021 SHALL, on commit, push (wr_ptr-commit_ptr+1) into the length queue and set commit_ptr to the new wr_ptr.
REQ-022 SHALL discard a frame: rewind wr_ptr to commit_ptr on wr_last with wr_err=1.
REQ-023 SHALL discard a frame: rewind wr_ptr to commit_ptr on a word arriving while the data store is full, then ignore words until and including wr_last.
REQ-024 SHALL discard a frame: ignore the whole frame when its first word arrives while the length queue is full.
REQ-025 SHALL implement the write FSM states IDLE (no frame open), FILL (frame open), DISCARD (ignoring until wr_last); every discard returns to IDLE after wr_last.
REQ-026 SHALL treat a single word with wr_last=1 in IDLE as a one-word frame, frm_len=1.
REQ-027 SHALL ignore rd_en when frm_avail=0; otherwise rd_data/rd_valid are registered with 1-cycle latency after rd_en.
REQ-028 SHALL assert rd_last with the frm_len-th word of the head frame, pop the length queue on that read, and free each word on its read.
REQ-029 SHALL correctly handle commit and last-word read in the same cycle: frame count is unchanged and frm_avail stays 1 if another frame remains.
REQ-030 SHALL compute afull from (wr_ptr-rd_ptr) registered, including uncommitted words.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously clear all pointers, the length queue count and drop_cnt, and set the FSM to IDLE.
REQ-032 SHALL hold rd_valid, rd_last, frm_avail and afull at 0, and rd_data, frm_len and drop_cnt at 0, during reset.
REQ-033 SHALL lose any partially written or stored frame on reset asserted mid-frame; the first word after release starts a new frame.

Configuration
REQ-034 SHALL, with FRAME_BUFF_DROP_CNT_EN defined, increment drop_cnt once per discarded frame, saturating at 16'hFFFF.
REQ-035 SHALL, without FRAME_BUFF_DROP_CNT_EN, tie drop_cnt to 0 and synthesise no counter.

Verification
REQ-036 SHALL cover: 64-word frame, wr_err=0, then rd_en held -> frm_len=64, 64 rd_valid words in order, rd_last on word 64, frm_avail falls.
REQ-037 SHALL cover: 100-word frame with wr_err=1 on wr_last -> frm_avail stays 0, occupancy back to 0, drop_cnt=1.
REQ-038 SHALL cover: ADDR_W=6, 70-word frame -> frame dropped; following 10-word frame -> committed, frm_len=10.
REQ-039 SHALL cover: FRM_W=2, five 1-word frames with no reads -> four committed, fifth dropped, drop_cnt=1.
REQ-040 SHALL cover: commit of frame B in the same cycle as rd_last of frame A -> frm_avail stays 1, frm_len switches to B's length.
REQ-041 SHALL cover: rst_n pulsed low mid-frame with 3 frames stored -> all outputs 0; next frame reads back correctly.
